// File: rtl/ps2_keypad_mapper_if.sv
// Bus bundle between the PS/2 keypad mapper and its host: scancode input, map-table write port,
// wait-for-key handshake and the keypad/hotkey/status outputs.
interface ps2_keypad_mapper_if #(
  parameter int unsigned NUM_KEYS    = 16,
  parameter int unsigned MAP_ENTRIES = 16,
  parameter int unsigned HOTKEYS     = 3
);
  localparam int unsigned KEY_W  = $clog2(NUM_KEYS);
  localparam int unsigned IDX_W  = $clog2(MAP_ENTRIES);
  // One extra bit so an out-of-range key index can be presented and rejected.
  localparam int unsigned MKEY_W = KEY_W + 1;

  logic [10:0]         ps2_key;
  logic                release_all;
  logic                map_we;
  logic [IDX_W-1:0]    map_idx;
  logic                map_valid;
  logic                map_ext;
  logic [7:0]          map_code;
  logic [MKEY_W-1:0]   map_key;
  logic                wait_req;
  logic [NUM_KEYS-1:0] key_matrix;
  logic [HOTKEYS-1:0]  hot_level;
  logic [HOTKEYS-1:0]  hot_pulse;
  logic                wait_valid;
  logic [KEY_W-1:0]    wait_key;
  logic                busy;
  logic                map_err;
  logic                overflow;

  modport master (
    output ps2_key, release_all, map_we, map_idx, map_valid, map_ext, map_code, map_key, wait_req,
    input  key_matrix, hot_level, hot_pulse, wait_valid, wait_key, busy, map_err, overflow
  );

  modport slave (
    input  ps2_key, release_all, map_we, map_idx, map_valid, map_ext, map_code, map_key, wait_req,
    output key_matrix, hot_level, hot_pulse, wait_valid, wait_key, busy, map_err, overflow
  );
endinterface

// File: rtl/ps2_keypad_mapper.sv
// Maps toggle-strobed PS/2 key events onto an N-key hex keypad through a remappable scancode
// table, with parallel hotkey decode and a one-shot wait-for-key handshake.
module ps2_keypad_mapper #(
  parameter int unsigned          NUM_KEYS    = 16,
  parameter int unsigned          MAP_ENTRIES = 16,
  parameter int unsigned          HOTKEYS     = 3,
  parameter logic [8*HOTKEYS-1:0] HOT_CODES   = {8'h09, 8'h78, 8'h07},
  parameter bit                   DEFAULT_MAP = 1'b1
) (
  input logic                clk,
  input logic                res,
  ps2_keypad_mapper_if.slave bus
);
  localparam int unsigned KEY_W  = $clog2(NUM_KEYS);
  localparam int unsigned IDX_W  = $clog2(MAP_ENTRIES);
  localparam int unsigned MKEY_W = KEY_W + 1;

  // chip8 layout 1234/QWER/ASDF/ZXCV; entry 0 in the low byte/nibble.
  localparam logic [127:0] DEF_CODES = {8'h2A, 8'h21, 8'h22, 8'h1A, 8'h2B, 8'h23, 8'h1B, 8'h1C,
                                        8'h2D, 8'h24, 8'h1D, 8'h15, 8'h25, 8'h26, 8'h1E, 8'h16};
  localparam logic [63:0]  DEF_KEYS  = {4'hF, 4'hB, 4'h0, 4'hA, 4'hE, 4'h9, 4'h8, 4'h7,
                                        4'hD, 4'h6, 4'h5, 4'h4, 4'hC, 4'h3, 4'h2, 4'h1};

  typedef struct packed {
    logic             valid;
    logic             ext;
    logic [7:0]       code;
    logic [KEY_W-1:0] key;
  } entry_t;

  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } evt_t;

  typedef enum logic {StIdle, StScan} state_e;

  function automatic entry_t reset_entry(int unsigned i);
    entry_t e;
    e = '0;
    if (DEFAULT_MAP && i < 16) begin
      e.valid = 1'b1;
      e.code  = DEF_CODES[8*i +: 8];
      e.key   = KEY_W'(DEF_KEYS[4*i +: 4]);
    end
    return e;
  endfunction

  state_e              state_q, state_d;
  entry_t              table_q [MAP_ENTRIES];
  entry_t              cur;
  evt_t                cap, evt_q, pend_q;
  logic                pend_valid_q;
  logic [IDX_W-1:0]    idx_q;
  logic                ref_q, primed_q;
  logic                evt_in, hit, last, busy;
  logic [NUM_KEYS-1:0] key_matrix_q;
  logic [HOTKEYS-1:0]  hot_level_q, hot_pulse_q, hot_hit;
  logic                wait_req_q, wait_rise, wait_valid_q;
  logic [KEY_W-1:0]    wait_key_q;
  logic                map_err_q, overflow_q;

  assign cap    = '{pressed: bus.ps2_key[9], ext: bus.ps2_key[8], code: bus.ps2_key[7:0]};
  assign evt_in = primed_q && (bus.ps2_key[10] != ref_q);
  assign cur    = table_q[idx_q];
  assign hit    = (state_q == StScan) && cur.valid && (cur.code == evt_q.code) &&
                  (cur.ext == evt_q.ext);
  assign last   = (idx_q == IDX_W'(MAP_ENTRIES - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (evt_in || pend_valid_q) state_d = StScan;
      StScan: if (hit || last)            state_d = StIdle;
      default:                            state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q != StIdle) || pend_valid_q;
    bus.busy = busy;
  end

  // The first edge out of reset only samples the strobe level.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ref_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      ref_q    <= bus.ps2_key[10];
      primed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      evt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      idx_q        <= '0;
      overflow_q   <= 1'b0;
    end else if (state_q == StIdle) begin
      idx_q <= '0;
      if (pend_valid_q) begin
        evt_q        <= pend_q;
        pend_valid_q <= evt_in;
        if (evt_in) pend_q <= cap;
      end else if (evt_in) begin
        evt_q <= cap;
      end
    end else begin
      if (!hit && !last) idx_q <= idx_q + 1'b1;
      if (evt_in) begin
        if (pend_valid_q) begin
          overflow_q <= 1'b1;
        end else begin
          pend_valid_q <= 1'b1;
          pend_q       <= cap;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      key_matrix_q <= '0;
      wait_req_q   <= 1'b0;
      wait_valid_q <= 1'b0;
      wait_key_q   <= '0;
    end else begin
      wait_req_q <= bus.wait_req;
      if (bus.release_all)  key_matrix_q          <= '0;
      else if (hit)         key_matrix_q[cur.key] <= evt_q.pressed;
      if (bus.wait_req && (!wait_valid_q || wait_rise) && hit && evt_q.pressed) begin
        wait_valid_q <= 1'b1;
        wait_key_q   <= cur.key;
      end else if (wait_rise || !bus.wait_req) begin
        wait_valid_q <= 1'b0;
      end
    end
  end

  assign wait_rise = bus.wait_req && !wait_req_q;

  always_comb begin
    for (int unsigned h = 0; h < HOTKEYS; h++) begin
      hot_hit[h] = evt_in && !bus.ps2_key[8] && (bus.ps2_key[7:0] == HOT_CODES[8*h +: 8]);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hot_level_q <= '0;
      hot_pulse_q <= '0;
    end else begin
      hot_pulse_q <= hot_hit & {HOTKEYS{bus.ps2_key[9]}} & ~hot_level_q;
      hot_level_q <= (hot_level_q & ~hot_hit) | (hot_hit & {HOTKEYS{bus.ps2_key[9]}});
    end
  end

  // Writes while busy are dropped silently so an in-flight scan sees a stable table.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int unsigned i = 0; i < MAP_ENTRIES; i++) table_q[i] <= reset_entry(i);
      map_err_q <= 1'b0;
    end else begin
      map_err_q <= 1'b0;
      if (bus.map_we && !busy) begin
        if (bus.map_key >= MKEY_W'(NUM_KEYS)) begin
          map_err_q <= 1'b1;
        end else begin
          table_q[bus.map_idx] <= {bus.map_valid, bus.map_ext, bus.map_code,
                                   bus.map_key[KEY_W-1:0]};
        end
      end
    end
  end

  assign bus.key_matrix = key_matrix_q;
  assign bus.hot_level  = hot_level_q;
  assign bus.hot_pulse  = hot_pulse_q;
  assign bus.wait_valid = wait_valid_q;
  assign bus.wait_key   = wait_key_q;
  assign bus.map_err    = map_err_q;
  assign bus.overflow   = overflow_q;
endmodule
